// File: rtl/stage_3_renorm_pipe_pkg.sv
// -----------------------------------------------------------------------------
// stage_3_renorm_pipe_pkg
// Shared constants, types and helpers for the stage-3 renormaliser of the
// AV1 arithmetic encoder.
//   CNT_INIT       : value of the signed bit counter after reset
//   PC_WORD_WIDTH  : width of a precarry word (carry bit + byte)
//   CARRY_BIT      : position of the carry flag inside a precarry word
//   pc_word_t      : one precarry word
//   push_cnt_e     : number of words produced by one accepted update
//   pc_push_t      : words produced by one accepted update, w0 goes first
//   leading_zero() : leading-zero count of the low 'width' bits of a value
// -----------------------------------------------------------------------------
package stage_3_renorm_pipe_pkg;

    localparam int CNT_INIT      = -9;
    localparam int PC_WORD_WIDTH = 9;
    localparam int CARRY_BIT     = 8;

    typedef logic [PC_WORD_WIDTH-1:0] pc_word_t;

    typedef enum logic [1:0] {
        PUSH_NONE = 2'd0,
        PUSH_ONE  = 2'd1,
        PUSH_TWO  = 2'd2
    } push_cnt_e;

    typedef struct packed {
        push_cnt_e n;
        pc_word_t  w0;
        pc_word_t  w1;
    } pc_push_t;

    // Leading zeros of v[width-1:0]; an all-zero field returns width.
    // Ascending scan so the highest set bit is the last to update the result.
    function automatic int leading_zero(input logic [63:0] v, input int width);
        int n;
        n = width;
        for (int i = 0; i < 64; i++) begin
            if ((i < width) && v[i]) begin
                n = width - 1 - i;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/stage_3_renorm_pipe_if.sv
// -----------------------------------------------------------------------------
// stage_3_renorm_pipe_if
// Bundles the stage-2 update handshake, the registered renormalised state
// fed back to stage 2, and the precarry word handshake toward the carry
// resolution stage.
//   in_valid/in_ready/in_range/in_low : update from stage 2
//   out_range/out_low/out_cnt         : registered renormalised state
//   pc_valid/pc_ready/pc_word         : precarry FIFO head
// Modports: slave = renormaliser, master = surrounding encoder / bench.
// -----------------------------------------------------------------------------
interface stage_3_renorm_pipe_if #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 32,
    parameter int D_SIZE      = 5
);
    import stage_3_renorm_pipe_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [RANGE_WIDTH-1:0] in_range;
    logic [LOW_WIDTH-1:0]   in_low;
    logic [RANGE_WIDTH-1:0] out_range;
    logic [LOW_WIDTH-1:0]   out_low;
    logic signed [D_SIZE:0] out_cnt;
    logic                   pc_valid;
    logic                   pc_ready;
    pc_word_t               pc_word;

    modport master (
        output in_valid, in_range, in_low, pc_ready,
        input  in_ready, out_range, out_low, out_cnt, pc_valid, pc_word
    );

    modport slave (
        input  in_valid, in_range, in_low, pc_ready,
        output in_ready, out_range, out_low, out_cnt, pc_valid, pc_word
    );

endinterface

// File: rtl/stage_3_renorm_pipe_precarry_fifo.sv
// -----------------------------------------------------------------------------
// precarry_fifo
// Power-of-two deep FIFO of precarry words accepting up to two pushes and
// one pop per clock.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (control state only)
//   push_i  : word count and words to append this edge (w0 before w1)
//   pop_i   : remove the head this edge (caller guarantees non-empty)
//   head_o  : oldest stored word
//   occ_o   : number of stored words
// The caller only pushes when at least two entries are free.
// -----------------------------------------------------------------------------
module precarry_fifo
    import stage_3_renorm_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  pc_push_t         push_i,
    input  logic             pop_i,
    output pc_word_t         head_o,
    output logic [OCC_W-1:0] occ_o
);

    localparam int AW = $clog2(DEPTH);

    pc_word_t         mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            wr_q  <= wr_q + AW'(push_i.n);
            rd_q  <= rd_q + AW'(pop_i);
            occ_q <= occ_q + OCC_W'(push_i.n) - OCC_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i.n != PUSH_NONE) begin
            mem_q[wr_q] <= push_i.w0;
        end
        if (push_i.n == PUSH_TWO) begin
            mem_q[wr_q + AW'(1)] <= push_i.w1;
        end
    end

    assign head_o = mem_q[rd_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/stage_3_renorm_pipe.sv
// -----------------------------------------------------------------------------
// stage_3_renorm_pipe
// Registered stage-3 renormaliser of the AV1 arithmetic encoder. Each
// accepted update normalises range by its leading-zero count d, shifts low
// by d, advances the signed bit counter cnt and emits zero, one or two
// 9-bit precarry words (bit 8 = carry) into an internal FIFO.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset
//   bus        : stage_3_renorm_pipe_if.slave
//                in_*  update handshake from stage 2
//                out_* registered range/low/cnt (latency 1)
//                pc_*  precarry FIFO head handshake
//   byte_count : [31:0] number of FIFO pops, only with STAGE3_BYTE_CNT_EN
// Configuration macro: STAGE3_BYTE_CNT_EN adds the byte_count port.
// -----------------------------------------------------------------------------
module stage_3_renorm_pipe #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 32,
    parameter int D_SIZE      = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    stage_3_renorm_pipe_if.slave bus
`ifdef STAGE3_BYTE_CNT_EN
    ,
    output logic [31:0]         byte_count
`endif
);
    import stage_3_renorm_pipe_pkg::*;

    localparam int CNT_W = D_SIZE + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [RANGE_WIDTH-1:0]  range_q, range_d;
    logic [LOW_WIDTH-1:0]    low_q, low_d;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;

    logic [OCC_W-1:0] occ;
    logic             in_ready;
    logic             accept;
    logic             pop;
    pc_word_t         head;
    pc_push_t         push_c;
    logic             word_ovf;

    int                   d_c;
    int                   s_c;
    int                   c_c;
    logic [LOW_WIDTH-1:0] l_c;
    logic [LOW_WIDTH-1:0] m_c;
    logic [LOW_WIDTH-1:0] x0_c;
    logic [LOW_WIDTH-1:0] x1_c;

    // Two free entries cover the worst case of one update; depends only on
    // registered occupancy so it never loops through in_valid.
    assign in_ready = (int'(occ) <= FIFO_DEPTH - 2);
    assign accept   = bus.in_valid && in_ready;
    assign pop      = bus.pc_ready && (occ != '0);

    always_comb begin
        d_c      = leading_zero(64'(bus.in_range), RANGE_WIDTH);
        s_c      = int'(cnt_q) + d_c;
        c_c      = int'(cnt_q) + 16;
        l_c      = bus.in_low;
        m_c      = (LOW_WIDTH'(1) << c_c) - LOW_WIDTH'(1);
        x0_c     = '0;
        x1_c     = '0;
        range_d  = range_q;
        low_d    = low_q;
        cnt_d    = cnt_q;
        push_c   = '{n: PUSH_NONE, w0: '0, w1: '0};
        word_ovf = 1'b0;

        // A zero range is accepted but leaves all state untouched.
        if (accept && (bus.in_range != '0)) begin
            range_d = bus.in_range << d_c;
            if (s_c < 0) begin
                low_d = bus.in_low << d_c;
                cnt_d = CNT_W'(s_c);
            end else begin
                // At least one whole byte has become final; a second one
                // is ready when s reaches 8.
                if (s_c >= 8) begin
                    x0_c = l_c >> c_c;
                    l_c  = l_c & m_c;
                    c_c  = c_c - 8;
                    m_c  = m_c >> 8;
                end
                x1_c  = l_c >> c_c;
                l_c   = l_c & m_c;
                cnt_d = CNT_W'(c_c + d_c - 24);
                low_d = l_c << d_c;
                if (s_c >= 8) begin
                    push_c = '{n: PUSH_TWO, w0: x0_c[PC_WORD_WIDTH-1:0],
                               w1: x1_c[PC_WORD_WIDTH-1:0]};
                end else begin
                    push_c = '{n: PUSH_ONE, w0: x1_c[PC_WORD_WIDTH-1:0], w1: '0};
                end
                word_ovf = (|(x0_c >> PC_WORD_WIDTH)) || (|(x1_c >> PC_WORD_WIDTH));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            range_q <= {1'b1, {(RANGE_WIDTH-1){1'b0}}};
            low_q   <= '0;
            cnt_q   <= CNT_W'(CNT_INIT);
        end else begin
            range_q <= range_d;
            low_q   <= low_d;
            cnt_q   <= cnt_d;
        end
    end

    precarry_fifo #(
        .DEPTH (FIFO_DEPTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (reset),
        .push_i (push_c),
        .pop_i  (pop),
        .head_o (head),
        .occ_o  (occ)
    );

`ifdef STAGE3_BYTE_CNT_EN
    logic [31:0] byte_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_count_q <= '0;
        end else if (pop) begin
            byte_count_q <= byte_count_q + 32'd1;
        end
    end

    assign byte_count = byte_count_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            assert (bus.in_range != '0);
            assert (!word_ovf);
        end
        if (reset) begin
            assert (int'(occ) <= FIFO_DEPTH);
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_range = range_q;
    assign bus.out_low   = low_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.pc_valid  = (occ != '0);
    assign bus.pc_word   = head;

endmodule

// File: tb/tb_stage_3_renorm_pipe.sv
// -----------------------------------------------------------------------------
// tb_stage_3_renorm_pipe
// Scoreboarded bench for stage_3_renorm_pipe: a reference model of the AV1
// renormalisation pushes expected precarry words, a negedge monitor pops and
// compares them as the DUT hands them out, and each test task compares the
// registered range/low/cnt after every accepted update.
// -----------------------------------------------------------------------------
module tb_stage_3_renorm_pipe;

    localparam int RW = 16;
    localparam int LW = 32;
    localparam int DS = 5;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    stage_3_renorm_pipe_if #(.RANGE_WIDTH(RW), .LOW_WIDTH(LW), .D_SIZE(DS)) bus ();

`ifdef STAGE3_BYTE_CNT_EN
    logic [31:0] byte_count;
`endif

    stage_3_renorm_pipe #(
        .RANGE_WIDTH (RW),
        .LOW_WIDTH   (LW),
        .D_SIZE      (DS),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
`ifdef STAGE3_BYTE_CNT_EN
        ,
        .byte_count (byte_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [8:0]  sb [$];
    logic [15:0] m_range;
    logic [31:0] m_low;
    int          m_cnt;

    // Reference renormalisation (od_ec_encode tail) on 64-bit integers.
    task automatic model_accept(input logic [15:0] r, input logic [31:0] l);
        int d, s, c;
        longint unsigned low, msk;
        logic [15:0] rr;
        d = 0;
        while (d < 16 && r[15-d] == 1'b0) d++;
        s   = m_cnt + d;
        rr  = r << d;
        m_range = rr;
        low = 64'(l);
        if (s < 0) begin
            m_low = 32'(low << d);
            m_cnt = s;
        end else begin
            c   = m_cnt + 16;
            msk = (64'd1 << c) - 64'd1;
            if (s >= 8) begin
                sb.push_back(9'(low >> c));
                low = low & msk;
                c   = c - 8;
                msk = msk >> 8;
            end
            sb.push_back(9'(low >> c));
            low   = low & msk;
            m_cnt = c + d - 24;
            m_low = 32'(low << d);
        end
    endtask

    // Word monitor: pc_valid must track the scoreboard, and every handshake
    // must deliver the oldest expected word.
    always @(negedge clk) begin
        logic [8:0] exp_w;
        if (rst_n) begin
            checks++;
            if (bus.pc_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL pc_valid actual=%0b required=%0b", bus.pc_valid, (sb.size() != 0));
            end
            if (bus.pc_valid === 1'b1 && bus.pc_ready === 1'b1 && sb.size() != 0) begin
                exp_w = sb.pop_front();
                pops++;
                checks++;
                if (bus.pc_word !== exp_w) begin
                    errors++;
                    $display("FAIL pc_word actual=0x%03h required=0x%03h", bus.pc_word, exp_w);
                end
            end
        end
    end

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        bus.pc_ready = 1'b0;
        bus.in_range = '0;
        bus.in_low   = '0;
        #2;
        rst_n   = 1'b0;
        sb.delete();
        m_range = 16'h8000;
        m_low   = '0;
        m_cnt   = -9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one update and wait (bounded) for it to be accepted; returns
    // 1 ns after the accepting edge.
    task automatic send(input logic [15:0] r, input logic [31:0] l);
        int n;
        bus.in_valid = 1'b1;
        bus.in_range = r;
        bus.in_low   = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout range=0x%04h waited=%0d required<=200", r, n);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        model_accept(r, l);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        @(posedge clk);
        #1;
        bus.pc_ready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.pc_valid === 1'b0) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout pc_valid=%0b cycles=%0d required<=100", bus.pc_valid, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.pc_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 5;
        if (bus.out_range !== 16'h8000) begin errors++; $display("FAIL rst_range actual=0x%04h required=0x8000", bus.out_range); end
        if (bus.out_low !== 32'h0) begin errors++; $display("FAIL rst_low actual=0x%08h required=0x0", bus.out_low); end
        if (bus.out_cnt !== 6'h37) begin errors++; $display("FAIL rst_cnt actual=%0d required=-9", bus.out_cnt); end
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL rst_pc_valid actual=%0b required=0", bus.pc_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready actual=%0b required=1", bus.in_ready); end
    endtask

    task automatic test_no_push();
        apply_reset();
        send(16'h4000, 32'h0000_1234);
        checks += 4;
        if (bus.out_range !== 16'h8000) begin errors++; $display("FAIL np_range actual=0x%04h required=0x8000", bus.out_range); end
        if (bus.out_low !== 32'h2468) begin errors++; $display("FAIL np_low actual=0x%08h required=0x2468", bus.out_low); end
        if (bus.out_cnt !== 6'h38) begin errors++; $display("FAIL np_cnt actual=%0d required=-8", bus.out_cnt); end
        @(negedge clk);
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL np_pc_valid actual=%0b required=0", bus.pc_valid); end
    endtask

    task automatic test_one_word();
        apply_reset();
        send(16'h0080, 32'h0000_ABCD);
        checks += 2;
        if (bus.out_low !== 32'h00AB_CD00) begin errors++; $display("FAIL ow_low0 actual=0x%08h required=0xabcd00", bus.out_low); end
        if (bus.out_cnt !== 6'h3F) begin errors++; $display("FAIL ow_cnt0 actual=%0d required=-1", bus.out_cnt); end
        send(16'h0800, 32'h00AB_CD00);
        checks += 3;
        if (bus.out_range !== 16'h8000) begin errors++; $display("FAIL ow_range actual=0x%04h required=0x8000", bus.out_range); end
        if (bus.out_low !== 32'h0004_D000) begin errors++; $display("FAIL ow_low1 actual=0x%08h required=0x4d000", bus.out_low); end
        if (bus.out_cnt !== 6'h3B) begin errors++; $display("FAIL ow_cnt1 actual=%0d required=-5", bus.out_cnt); end
        @(negedge clk);
        checks++;
        if (bus.pc_word !== 9'h157) begin errors++; $display("FAIL ow_word actual=0x%03h required=0x157", bus.pc_word); end
        drain();
    endtask

    task automatic test_two_words();
        apply_reset();
        send(16'h0080, 32'h0000_ABCD);
        send(16'h0040, 32'h00AB_CD00);
        checks += 3;
        if (bus.out_range !== 16'h8000) begin errors++; $display("FAIL tw_range actual=0x%04h required=0x8000", bus.out_range); end
        if (bus.out_low !== 32'h0) begin errors++; $display("FAIL tw_low actual=0x%08h required=0x0", bus.out_low); end
        if (bus.out_cnt !== 6'h38) begin errors++; $display("FAIL tw_cnt actual=%0d required=-8", bus.out_cnt); end
        @(negedge clk);
        checks++;
        if (bus.pc_word !== 9'h157) begin errors++; $display("FAIL tw_word0 actual=0x%03h required=0x157", bus.pc_word); end
        @(posedge clk);
        #1 bus.pc_ready = 1'b1;
        @(posedge clk);
        #1 bus.pc_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pc_word !== 9'h09A) begin errors++; $display("FAIL tw_word1 actual=0x%03h required=0x09a", bus.pc_word); end
        drain();
    endtask

    task automatic test_backpressure();
        apply_reset();
        send(16'h0080, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            send(16'h0080, 32'h0010_0000 + 32'(i) * 32'h0001_2345);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full actual=%0b required=0", bus.in_ready); end
        fork
            send(16'h0080, 32'h00FE_DCBA);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checks += 2;
                    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready actual=%0b required=0", bus.in_ready); end
                    if (bus.pc_word !== sb[0]) begin errors++; $display("FAIL bp_head_stable actual=0x%03h required=0x%03h", bus.pc_word, sb[0]); end
                end
                @(posedge clk);
                #1 bus.pc_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_empty actual=%0b required=1", bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send(16'h0080, 32'h0000_0001);
        send(16'h0080, 32'h0020_0000);
        send(16'h0080, 32'h0030_0000);
        #2;
        rst_n   = 1'b0;
        sb.delete();
        m_range = 16'h8000;
        m_low   = '0;
        m_cnt   = -9;
        #1;
        checks += 4;
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL mr_pc_valid actual=%0b required=0", bus.pc_valid); end
        if (bus.out_cnt !== 6'h37) begin errors++; $display("FAIL mr_cnt actual=%0d required=-9", bus.out_cnt); end
        if (bus.out_range !== 16'h8000) begin errors++; $display("FAIL mr_range actual=0x%04h required=0x8000", bus.out_range); end
        if (bus.out_low !== 32'h0) begin errors++; $display("FAIL mr_low actual=0x%08h required=0x0", bus.out_low); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit done;
        apply_reset();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [15:0] r;
                    logic [31:0] l;
                    r = 16'($urandom_range(1, 16'hFFFF));
                    l = $urandom & 32'((64'd1 << (m_cnt + 25)) - 64'd1);
                    send(r, l);
                    checks += 3;
                    if (bus.out_range !== m_range) begin errors++; $display("FAIL b2b_range actual=0x%04h required=0x%04h", bus.out_range, m_range); end
                    if (bus.out_low !== m_low) begin errors++; $display("FAIL b2b_low actual=0x%08h required=0x%08h", bus.out_low, m_low); end
                    if (bus.out_cnt !== 6'(m_cnt)) begin errors++; $display("FAIL b2b_cnt actual=%0d required=%0d", bus.out_cnt, m_cnt); end
                end
                done = 1'b1;
            end
            begin
                for (int n = 0; n < 5000 && !done; n++) begin
                    @(posedge clk);
                    #1 bus.pc_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
    endtask

`ifdef STAGE3_BYTE_CNT_EN
    task automatic test_byte_count();
        apply_reset();
        send(16'h0080, 32'h0000_0001);
        bus.pc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(16'h0080, 32'h0040_0000 + 32'(i) * 32'h0000_1111);
        end
        drain();
        checks++;
        if (byte_count !== 32'd5) begin errors++; $display("FAIL bc_five actual=%0d required=5", byte_count); end
        send(16'h0080, 32'h0050_0000);
        dut.byte_count_q = 32'hFFFF_FFFF;
        drain();
        checks++;
        if (byte_count !== 32'd0) begin errors++; $display("FAIL bc_wrap actual=0x%08h required=0x0", byte_count); end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.pc_ready = 1'b0;
        bus.in_range = '0;
        bus.in_low   = '0;
        m_range = 16'h8000;
        m_low   = '0;
        m_cnt   = -9;
        test_reset();
        test_no_push();
        test_one_word();
        test_two_words();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef STAGE3_BYTE_CNT_EN
        test_byte_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required=finish_before_timeout", $time);
        $fatal(1);
    end

endmodule
